// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, latch indices and rule priority helper for pipe_ctrl
// Ports: none (package).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

    // Bit positions of the pipeline latches inside en/flush.
    localparam int L1 = 0;  // IF/ID
    localparam int L2 = 1;  // ID/EX
    localparam int L3 = 2;  // EX/MEM
    localparam int L4 = 3;  // MEM/WB

    typedef enum logic [2:0] {
        RULE_MEM_STALL = 3'd0,
        RULE_BRANCH    = 3'd1,
        RULE_LOAD_USE  = 3'd2,
        RULE_HALT      = 3'd3,
        RULE_NONE      = 3'd4
    } rule_t;

    // Strict priority: memory stall > branch > load-use > halt > nothing.
    function automatic rule_t pick_rule(input logic mem_stall,
                                        input logic branch,
                                        input logic load_use,
                                        input logic halt_req);
        if (mem_stall)     return RULE_MEM_STALL;
        else if (branch)   return RULE_BRANCH;
        else if (load_use) return RULE_LOAD_USE;
        else if (halt_req) return RULE_HALT;
        else               return RULE_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline-control signal bundle between datapath and pipe_ctrl
// Ports (master = datapath side, slave = controller side):
//   datapath -> ctrl : ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2, branch_taken,
//                      mem_req, mem_ready, halt, go
//   ctrl -> datapath : pc_en, en[3:0], flush[1:0], halted, mem_err, stall_count[CNT_W-1:0]
interface pipe_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             ex_mem_read;
    logic [2:0]       ex_rd;
    logic [2:0]       id_rs1;
    logic [2:0]       id_rs2;
    logic             id_uses_rs2;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             halt;
    logic             go;

    logic             pc_en;
    logic [3:0]       en;
    logic [1:0]       flush;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2, branch_taken,
               mem_req, mem_ready, halt, go,
        input  pc_en, en, flush, halted, mem_err, stall_count
    );

    modport slave (
        input  ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2, branch_taken,
               mem_req, mem_ready, halt, go,
        output pc_en, en, flush, halted, mem_err, stall_count
    );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
// Ports: ex_mem_read, ex_rd[2:0], id_rs1[2:0], id_rs2[2:0], id_uses_rs2 in; load_use out.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [2:0] ex_rd,
    input  logic [2:0] id_rs1,
    input  logic [2:0] id_rs2,
    input  logic       id_uses_rs2,
    output logic       load_use
);
    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 3'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 4-latch pipeline stall/flush/halt controller
// Ports: clk2 (pipeline clock), rst (sync active-high reset), bus (pipe_ctrl_if.slave):
//   hazard/branch/memory/halt inputs in, pc_en/en/flush/halted/mem_err/stall_count out.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic      clk2,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    localparam int               WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_next;
    logic [WAIT_W-1:0]  wait_cnt, wait_next, wait_inc;
    logic               mem_err, err_set;
    logic [CNT_W-1:0]   stall_count;
    logic               load_use;
    logic               follow_rules;
    rule_t              rule;

    logic               pc_en;
    logic [3:0]         en;
    logic [1:0]         flush;
    logic               halted;

    hazard_detect u_hazard (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs2 (bus.id_uses_rs2),
        .load_use    (load_use)
    );

    // The LOAD_STALL cycle already holds the dependent instruction; re-checking
    // load-use there would stall twice for one hazard. In MEM_WAIT the rules only
    // apply once mem_ready=1, which makes the memory-stall term zero by itself.
    assign rule = pick_rule(bus.mem_req && !bus.mem_ready, bus.branch_taken,
                            load_use && (state != ST_LOAD_STALL), bus.halt);

    assign follow_rules = (state == ST_RUN) || (state == ST_LOAD_STALL) ||
                          ((state == ST_MEM_WAIT) && bus.mem_ready);

    assign wait_inc = wait_cnt + WAIT_W'(1);

    // State register
    always_ff @(posedge clk2) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (err_set) begin
                mem_err <= 1'b1;
            end
            if (!pc_en && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        err_set    = 1'b0;
        if (follow_rules) begin
            case (rule)
                RULE_MEM_STALL: begin
                    state_next = ST_MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end
                RULE_LOAD_USE: state_next = ST_LOAD_STALL;
                RULE_HALT:     state_next = ST_HALT;
                default:       state_next = ST_RUN;
            endcase
        end else begin
            case (state)
                ST_MEM_WAIT: begin
                    wait_next = wait_inc;
                    if (wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
                        err_set    = 1'b1;
                        state_next = ST_HALT;
                    end
                end
                ST_HALT: begin
                    // A memory timeout is fatal until reset.
                    if (bus.go && !mem_err) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        pc_en  = 1'b0;
        en     = '0;
        flush  = '0;
        halted = 1'b0;
        if (!rst) begin
            if (state == ST_HALT) begin
                halted = 1'b1;
            end
            if (follow_rules) begin
                case (rule)
                    RULE_BRANCH: begin
                        pc_en     = 1'b1;
                        en        = 4'b1111;
                        flush[L1] = 1'b1;
                        flush[L2] = 1'b1;
                    end
                    RULE_LOAD_USE: begin
                        // Hold PC and IF/ID, push a bubble into ID/EX.
                        en        = 4'b1111;
                        en[L1]    = 1'b0;
                        flush[L2] = 1'b1;
                    end
                    RULE_NONE: begin
                        pc_en = 1'b1;
                        en    = 4'b1111;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.en          = en;
    assign bus.flush       = flush;
    assign bus.halted      = halted;
    assign bus.mem_err     = mem_err;
    assign bus.stall_count = stall_count;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters: MEM_TIMEOUT, default 15, max MEM_WAIT cycles before error; CNT_W, default 8, stall_count width.
REQ-002 clk2  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_mem_read  in  1  instruction in EX is a load.
REQ-005 ex_rd  in  3  destination register of EX instruction.
REQ-006 id_rs1, id_rs2  in  3 each  source registers of ID instruction.
REQ-007 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-008 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-009 mem_req, mem_ready  in  1 each  MEM-stage access request and completion.
REQ-010 halt, go  in  1 each  halt request; resume from HALT.
REQ-011 pc_en  out  1  PC update enable.
REQ-012 en  out  4  latch enables, bit0=L1 (IF/ID) .. bit3=L4 (MEM/WB).
REQ-013 flush  out  2  bubble inject, bit0=L1, bit1=L2 (latch loads zero when en and flush both set).
REQ-014 halted, mem_err  out  1 each  in HALT state; sticky memory timeout.
REQ-015 stall_count  out  CNT_W  saturating count of cycles with pc_en=0.

Function
REQ-016 States RUN, LOAD_STALL, MEM_WAIT, HALT; pc_en/en/flush are combinational from state and current inputs; state, counters, mem_err are registered.
REQ-017 Load-use hazard = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-018 RUN rules, strict priority: (1) mem_req & !mem_ready; (2) branch_taken; (3) load-use; (4) halt; (5) none.
REQ-019 Rule 1: pc_en=0, en=0000, flush=00, wait counter cleared to 1, next MEM_WAIT.
REQ-020 Rule 2: pc_en=1, en=1111, flush=11, next RUN; a simultaneous load-use or halt is ignored that cycle.
REQ-021 Rule 3: pc_en=0, en=1110, flush=10, next LOAD_STALL.
REQ-022 Rule 4: pc_en=0, en=0000, flush=00, next HALT.
REQ-023 Rule 5: pc_en=1, en=1111, flush=00, stay RUN.
REQ-024 LOAD_STALL: exactly one cycle; applies RUN rules 1, 2, 4, 5 (load-use not re-evaluated), then per those rules, else RUN.
REQ-025 MEM_WAIT, mem_ready=0: pc_en=0, en=0000, flush=00, wait counter +1; when counter reaches MEM_TIMEOUT, set mem_err, next HALT.
REQ-026 MEM_WAIT, mem_ready=1: apply RUN rules 2-5 in the same cycle; mem_ready on the timeout cycle wins over timeout.
REQ-027 HALT: pc_en=0, en=0000, flush=00, halted=1; go=1 and mem_err=0 -> RUN next cycle; with mem_err=1 leaves HALT only on rst.
REQ-028 stall_count increments on every cycle with pc_en=0, saturates at 2^CNT_W-1, never wraps.

Reset
REQ-029 rst=1 at a clock edge: state=RUN, stall_count=0, wait counter=0, mem_err=0, regardless of current state (incl. mid MEM_WAIT or HALT).
REQ-030 While rst=1: pc_en=0, en=0000, flush=00, halted=0; first post-reset cycle behaves as RUN.

Structure
REQ-031 State encoding enum and latch-bit index constants (L1..L4) reside in shared package pipe_pkg.
REQ-032 One sub-module hazard_detect (pure combinational load-use compare, REQ-017); remainder in pipe_ctrl.

Verification
REQ-033 ex_mem_read=1, ex_rd=3, id_rs1=3 for one cycle -> en=1110, flush=10, pc_en=0; next cycle en=1111; stall_count=1.
REQ-034 Same as 033 with ex_rd=0 -> no stall, en=1111.
REQ-035 Load-use and branch_taken together -> en=1111, flush=11, state RUN, stall_count unchanged.
REQ-036 mem_req=1, mem_ready low 4 cycles then high -> en=0000 for 4 cycles, then 1111; stall_count=4, mem_err=0.
REQ-037 mem_req=1, mem_ready held 0 -> mem_err=1 and halted=1 after MEM_TIMEOUT=15 cycles; go ignored; rst clears to RUN.
REQ-038 halt pulse, go after 300 cycles -> halted=1 throughout, stall_count saturates at 255, RUN after go.
